// File: rtl/host_load_sequencer_if.sv
// Host load sequencer bus bundle.
// Groups the input-buffer handshake, the instruction/weight load ports, the
// controller XY request, the muxed XY write port and the status outputs.
//   master : drives buffer_empty/buffer_data and the ctrl_xy_* request,
//            observes everything the sequencer produces.
//   slave  : the sequencer side.
interface host_load_sequencer_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NU_COUNT       = 8,
  parameter int unsigned INST_MEM_DEPTH = 8,
  parameter int unsigned W_MEM_DEPTH    = 9,
  parameter int unsigned XY_MEM_DEPTH   = 10
);
  logic                      buffer_empty;
  logic [DATA_WIDTH-1:0]     buffer_data;
  logic                      buffer_read_enable;
  logic                      inst_write_enable;
  logic [INST_MEM_DEPTH-1:0] inst_write_addr;
  logic [NU_COUNT-1:0]       w_write_enable;
  logic [W_MEM_DEPTH-1:0]    w_write_addr;
  logic [DATA_WIDTH-1:0]     load_write_data;
  logic                      ctrl_xy_write_enable;
  logic [XY_MEM_DEPTH-1:0]   ctrl_xy_write_addr;
  logic [DATA_WIDTH-1:0]     ctrl_xy_write_data;
  logic                      xy_write_enable;
  logic [XY_MEM_DEPTH-1:0]   xy_write_addr;
  logic [DATA_WIDTH-1:0]     xy_write_data;
  logic                      controller_reset;
  logic                      busy;
  logic                      error;

  modport master (
    output buffer_empty, buffer_data,
    output ctrl_xy_write_enable, ctrl_xy_write_addr, ctrl_xy_write_data,
    input  buffer_read_enable,
    input  inst_write_enable, inst_write_addr,
    input  w_write_enable, w_write_addr, load_write_data,
    input  xy_write_enable, xy_write_addr, xy_write_data,
    input  controller_reset, busy, error
  );

  modport slave (
    input  buffer_empty, buffer_data,
    input  ctrl_xy_write_enable, ctrl_xy_write_addr, ctrl_xy_write_data,
    output buffer_read_enable,
    output inst_write_enable, inst_write_addr,
    output w_write_enable, w_write_addr, load_write_data,
    output xy_write_enable, xy_write_addr, xy_write_data,
    output controller_reset, busy, error
  );
endinterface

// File: rtl/host_load_sequencer.sv
// host_load_sequencer: drains host words from a show-ahead input buffer and
// routes them to instruction memory, per-NU weight banks and XY memory.
// Gates the layer controller's reset via CMD headers and arbitrates the XY
// write port (controller has fixed priority over host loads).
// Ports: clk, reset (async, active-high), bus (host_load_sequencer_if.slave).
// Optional macro HOST_LOAD_BCAST_EN: weight bank 63 broadcasts to all banks;
// when undefined bank 63 is rejected as an invalid bank.
module host_load_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NU_COUNT       = 8,
  parameter int unsigned INST_MEM_DEPTH = 8,
  parameter int unsigned W_MEM_DEPTH    = 9,
  parameter int unsigned XY_MEM_DEPTH   = 10
) (
  input logic                  clk,
  input logic                  reset,
  host_load_sequencer_if.slave bus
);
  localparam int unsigned AW_IW = (INST_MEM_DEPTH > W_MEM_DEPTH) ? INST_MEM_DEPTH : W_MEM_DEPTH;
  localparam int unsigned AW    = (AW_IW > XY_MEM_DEPTH) ? AW_IW : XY_MEM_DEPTH;
  localparam int unsigned LEN_W = 12;
  localparam int unsigned EXT_W = LEN_W + 1;

  localparam logic [1:0] T_INST = 2'd0;
  localparam logic [1:0] T_W    = 2'd1;
  localparam logic [1:0] T_XY   = 2'd2;
  localparam logic [1:0] T_CMD  = 2'd3;

  // One past the last legal address of each memory, in the widened domain.
  localparam logic [EXT_W-1:0] INST_LIMIT = EXT_W'(1) << INST_MEM_DEPTH;
  localparam logic [EXT_W-1:0] W_LIMIT    = EXT_W'(1) << W_MEM_DEPTH;
  localparam logic [EXT_W-1:0] XY_LIMIT   = EXT_W'(1) << XY_MEM_DEPTH;

  typedef enum logic [1:0] {HEADER, DATA, ERROR} state_t;

  state_t           state;
  logic [1:0]       target_q;
  logic [5:0]       bank_q;
  logic [AW-1:0]    addr_q;
  logic [LEN_W-1:0] count_q;
  logic             ctrl_rst_q;

  // Header field decode of the buffer head word.
  logic [1:0]       h_target;
  logic [5:0]       h_bank;
  logic [LEN_W-1:0] h_start;
  logic [LEN_W-1:0] h_len;
  logic [EXT_W-1:0] h_end;
  logic             bank_ok;
  logic             hdr_bad;

  assign h_target = bus.buffer_data[31:30];
  assign h_bank   = bus.buffer_data[29:24];
  assign h_start  = bus.buffer_data[23:12];
  assign h_len    = bus.buffer_data[11:0];
  assign h_end    = EXT_W'(h_start) + EXT_W'(h_len);

`ifdef HOST_LOAD_BCAST_EN
  assign bank_ok = (32'(h_bank) < NU_COUNT) || (h_bank == 6'd63);
`else
  assign bank_ok = (32'(h_bank) < NU_COUNT);
`endif

  // Memories may only be rewritten while the controller is held in reset.
  always_comb begin
    hdr_bad = 1'b0;
    case (h_target)
      T_INST:  hdr_bad = (h_end > INST_LIMIT) || !ctrl_rst_q;
      T_W:     hdr_bad = (h_end > W_LIMIT) || !bank_ok || !ctrl_rst_q;
      T_XY:    hdr_bad = (h_end > XY_LIMIT);
      default: hdr_bad = 1'b0;
    endcase
  end

  // Pop control: controller XY writes stall an XY data pop.
  logic in_data;
  logic xy_stall;
  logic pop;
  logic wr_inst;
  logic wr_w;
  logic wr_xy;

  assign in_data  = (state == DATA);
  assign xy_stall = in_data && (target_q == T_XY) && bus.ctrl_xy_write_enable;
  assign pop      = (state != ERROR) && !bus.buffer_empty && !xy_stall;
  assign wr_inst  = pop && in_data && (target_q == T_INST);
  assign wr_w     = pop && in_data && (target_q == T_W);
  assign wr_xy    = pop && in_data && (target_q == T_XY);

  // Sequencer state, load address/count and controller reset gate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HEADER;
      target_q   <= T_INST;
      bank_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      ctrl_rst_q <= 1'b1;
    end else begin
      case (state)
        HEADER: begin
          if (pop) begin
            if (h_target == T_CMD) begin
              ctrl_rst_q <= ~bus.buffer_data[0];
            end else if (hdr_bad) begin
              state <= ERROR;
            end else if (h_len != '0) begin
              state    <= DATA;
              target_q <= h_target;
              bank_q   <= h_bank;
              addr_q   <= AW'(h_start);
              count_q  <= h_len;
            end
          end
        end
        DATA: begin
          if (pop) begin
            addr_q  <= addr_q + AW'(1);
            count_q <= count_q - LEN_W'(1);
            if (count_q == LEN_W'(1)) state <= HEADER;
          end
        end
        ERROR:   state <= ERROR;
        default: state <= HEADER;
      endcase
    end
  end

  // Weight strobes: one-hot by bank, or all banks for the broadcast bank.
  logic [NU_COUNT-1:0] w_mask;
  always_comb begin
    w_mask = '0;
    if (wr_w) begin
`ifdef HOST_LOAD_BCAST_EN
      if (bank_q == 6'd63) w_mask = '1;
      else                 w_mask = NU_COUNT'(1) << bank_q;
`else
      w_mask = NU_COUNT'(1) << bank_q;
`endif
    end
  end

  assign bus.buffer_read_enable = pop;
  assign bus.inst_write_enable  = wr_inst;
  assign bus.inst_write_addr    = addr_q[INST_MEM_DEPTH-1:0];
  assign bus.w_write_enable     = w_mask;
  assign bus.w_write_addr       = addr_q[W_MEM_DEPTH-1:0];
  assign bus.load_write_data    = bus.buffer_data;

  // XY port mux: controller wins whenever it requests.
  assign bus.xy_write_enable = bus.ctrl_xy_write_enable || wr_xy;
  assign bus.xy_write_addr   = bus.ctrl_xy_write_enable ? bus.ctrl_xy_write_addr
                                                        : addr_q[XY_MEM_DEPTH-1:0];
  assign bus.xy_write_data   = bus.ctrl_xy_write_enable ? bus.ctrl_xy_write_data
                                                        : bus.buffer_data;

  assign bus.controller_reset = ctrl_rst_q;
  assign bus.busy             = (state != HEADER);
  assign bus.error            = (state == ERROR);
endmodule

// File: tb/tb_host_load_sequencer.sv
// Self-checking bench for host_load_sequencer: a host buffer model feeds
// words, per-port scoreboards hold expected writes, a monitor compares them.
module tb_host_load_sequencer;
  localparam int unsigned DW = 32;
  localparam int unsigned NU = 8;
  localparam int unsigned ID = 8;
  localparam int unsigned WD = 9;
  localparam int unsigned XD = 10;

  typedef struct {
    logic [11:0]   addr;
    logic [DW-1:0] data;
    logic [NU-1:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;

  logic [DW-1:0] host_q[$];
  exp_t          inst_q[$];
  exp_t          w_q[$];
  exp_t          xy_q[$];

  host_load_sequencer_if #(.DATA_WIDTH(DW), .NU_COUNT(NU), .INST_MEM_DEPTH(ID),
                           .W_MEM_DEPTH(WD), .XY_MEM_DEPTH(XD)) bus ();

  host_load_sequencer #(.DATA_WIDTH(DW), .NU_COUNT(NU), .INST_MEM_DEPTH(ID),
                        .W_MEM_DEPTH(WD), .XY_MEM_DEPTH(XD)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] hdr(input int t, input int b, input int s, input int l);
    return {2'(t), 6'(b), 12'(s), 12'(l)};
  endfunction

  function automatic exp_t mk(input int a, input logic [DW-1:0] d, input logic [NU-1:0] m);
    exp_t e;
    e.addr = 12'(a); e.data = d; e.mask = m;
    return e;
  endfunction

  task automatic refresh();
    bus.buffer_empty = (host_q.size() == 0);
    bus.buffer_data  = (host_q.size() == 0) ? '0 : host_q[0];
  endtask

  task automatic push(input logic [DW-1:0] w);
    host_q.push_back(w);
    refresh();
  endtask

  // Host buffer: pop after the edge that consumed the head word.
  always @(posedge clk) begin
    if (bus.buffer_read_enable) begin
      #1;
      if (host_q.size() != 0) void'(host_q.pop_front());
      pops++;
      refresh();
    end
  end

  // Write monitor, sampled well after the falling edge.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (bus.inst_write_enable) begin
      total++;
      if (inst_q.size() == 0) begin
        bad++; $display("FAIL inst_unexpected addr=%h data=%h", bus.inst_write_addr, bus.load_write_data);
      end else begin
        e = inst_q.pop_front();
        if (bus.inst_write_addr !== ID'(e.addr) || bus.load_write_data !== e.data) begin
          bad++; $display("FAIL inst_write got %h/%h want %h/%h", bus.inst_write_addr, bus.load_write_data, ID'(e.addr), e.data);
        end
      end
    end
    if (bus.w_write_enable != '0) begin
      total++;
      if (w_q.size() == 0) begin
        bad++; $display("FAIL w_unexpected mask=%h addr=%h", bus.w_write_enable, bus.w_write_addr);
      end else begin
        e = w_q.pop_front();
        if (bus.w_write_enable !== e.mask || bus.w_write_addr !== WD'(e.addr) || bus.load_write_data !== e.data) begin
          bad++; $display("FAIL w_write got %h/%h/%h want %h/%h/%h", bus.w_write_enable, bus.w_write_addr, bus.load_write_data, e.mask, WD'(e.addr), e.data);
        end
      end
    end
    if (bus.xy_write_enable) begin
      total++;
      if (xy_q.size() == 0) begin
        bad++; $display("FAIL xy_unexpected addr=%h data=%h", bus.xy_write_addr, bus.xy_write_data);
      end else begin
        e = xy_q.pop_front();
        if (bus.xy_write_addr !== XD'(e.addr) || bus.xy_write_data !== e.data) begin
          bad++; $display("FAIL xy_write got %h/%h want %h/%h", bus.xy_write_addr, bus.xy_write_data, XD'(e.addr), e.data);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    host_q.delete();
    refresh();
    reset = 1'b1;
    bus.ctrl_xy_write_enable = 1'b0;
    repeat (2) @(negedge clk);
    inst_q.delete(); w_q.delete(); xy_q.delete();
    reset = 1'b0;
  endtask

  // Wait (bounded) until the buffer is drained and the sequencer is idle.
  task automatic wait_drain(output int cycles);
    cycles = 0;
    while ((host_q.size() != 0 || bus.busy) && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    total++;
    if (bus.controller_reset !== 1'b1 || bus.busy !== 1'b0 || bus.error !== 1'b0) begin
      bad++; $display("FAIL reset_status crst/busy/err=%b%b%b want 100", bus.controller_reset, bus.busy, bus.error);
    end
    total++;
    if (bus.buffer_read_enable !== 1'b0 || bus.inst_write_enable !== 1'b0 || bus.w_write_enable !== '0 ||
        bus.xy_write_enable !== 1'b0) begin
      bad++; $display("FAIL reset_strobes re/inst/w/xy=%b/%b/%h/%b want all 0", bus.buffer_read_enable,
                      bus.inst_write_enable, bus.w_write_enable, bus.xy_write_enable);
    end
    total++;
    if (bus.inst_write_addr !== '0 || bus.w_write_addr !== '0 || bus.xy_write_addr !== '0) begin
      bad++; $display("FAIL reset_addrs %h/%h/%h want 0", bus.inst_write_addr, bus.w_write_addr, bus.xy_write_addr);
    end
  endtask

  task automatic test_inst_load();
    int cyc;
    @(negedge clk);
    inst_q.push_back(mk(4, 32'hAAAA_0001, '0));
    inst_q.push_back(mk(5, 32'hBBBB_0002, '0));
    inst_q.push_back(mk(6, 32'hCCCC_0003, '0));
    push(hdr(0, 0, 4, 3)); push(32'hAAAA_0001); push(32'hBBBB_0002); push(32'hCCCC_0003);
    wait_drain(cyc);
    total++;
    if (cyc !== 4) begin bad++; $display("FAIL inst_throughput cycles=%0d want 4", cyc); end
    total++;
    if (inst_q.size() !== 0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL inst_done pending=%0d busy=%b want 0/0", inst_q.size(), bus.busy);
    end
  endtask

  task automatic test_w_load();
    int cyc;
    logic [DW-1:0] d0 = $urandom();
    logic [DW-1:0] d1 = $urandom();
    @(negedge clk);
    w_q.push_back(mk(12'h010, d0, 8'b0000_0100));
    w_q.push_back(mk(12'h011, d1, 8'b0000_0100));
    push(hdr(1, 2, 12'h010, 2)); push(d0); push(d1);
    wait_drain(cyc);
    total++;
    if (w_q.size() !== 0 || cyc !== 3) begin
      bad++; $display("FAIL w_done pending=%0d cycles=%0d want 0/3", w_q.size(), cyc);
    end
  endtask

  task automatic test_xy_conflict();
    int cyc;
    int p0;
    logic [DW-1:0] d[4];
    @(negedge clk);
    for (int i = 0; i < 4; i++) d[i] = $urandom();
    xy_q.push_back(mk(10'h3AB, 32'hC0DE_0001, '0));
    xy_q.push_back(mk(10'h3AC, 32'hC0DE_0002, '0));
    for (int i = 0; i < 4; i++) xy_q.push_back(mk(12'h020 + i, d[i], '0));
    push(hdr(2, 0, 12'h020, 4));
    for (int i = 0; i < 4; i++) push(d[i]);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.ctrl_xy_write_enable = 1'b1;
      bus.ctrl_xy_write_addr   = XD'(10'h3AB + c);
      bus.ctrl_xy_write_data   = 32'hC0DE_0001 + DW'(c);
      p0 = pops;
      #3;
      total++;
      if (bus.buffer_read_enable !== 1'b0) begin
        bad++; $display("FAIL xy_stall cycle=%0d read_enable=%b want 0", c, bus.buffer_read_enable);
      end
    end
    @(negedge clk);
    total++;
    if (pops !== p0) begin bad++; $display("FAIL xy_stall_pops got=%0d want %0d", pops, p0); end
    bus.ctrl_xy_write_enable = 1'b0;
    wait_drain(cyc);
    total++;
    if (xy_q.size() !== 0 || cyc !== 4) begin
      bad++; $display("FAIL xy_done pending=%0d cycles=%0d want 0/4", xy_q.size(), cyc);
    end
  endtask

  task automatic test_run_gating();
    @(negedge clk);
    push(32'hC000_0001);
    @(negedge clk);
    total++;
    if (bus.controller_reset !== 1'b0) begin
      bad++; $display("FAIL run_on controller_reset=%b want 0", bus.controller_reset);
    end
    push(32'hC000_0000);
    @(negedge clk);
    total++;
    if (bus.controller_reset !== 1'b1) begin
      bad++; $display("FAIL run_off controller_reset=%b want 1", bus.controller_reset);
    end
    push(32'hC000_0001);
    @(negedge clk);
    push(hdr(0, 0, 0, 1)); push(32'h1234_5678);
    repeat (3) @(negedge clk);
    total++;
    if (bus.error !== 1'b1 || host_q.size() !== 1) begin
      bad++; $display("FAIL inst_while_running error=%b left=%0d want 1/1", bus.error, host_q.size());
    end
    do_reset();
    total++;
    if (bus.controller_reset !== 1'b1 || bus.error !== 1'b0) begin
      bad++; $display("FAIL reset_after_run crst/err=%b%b want 10", bus.controller_reset, bus.error);
    end
  endtask

  task automatic test_bad_bank();
    int p0;
    @(negedge clk);
    p0 = pops;
    push(hdr(1, 9, 0, 1)); push(32'hDEAD_BEEF);
    @(negedge clk);
    total++;
    if (bus.error !== 1'b1) begin bad++; $display("FAIL bank9_error error=%b want 1", bus.error); end
    repeat (3) @(negedge clk);
    total++;
    if (pops - p0 !== 1 || bus.buffer_read_enable !== 1'b0) begin
      bad++; $display("FAIL bank9_nopop pops=%0d re=%b want 1/0", pops - p0, bus.buffer_read_enable);
    end
    do_reset();
  endtask

  task automatic test_bounds();
    int cyc;
    int p0;
    @(negedge clk);
    push(hdr(0, 0, 12'h0FE, 3)); push(32'h1); push(32'h2); push(32'h3);
    repeat (3) @(negedge clk);
    total++;
    if (bus.error !== 1'b1 || host_q.size() !== 3) begin
      bad++; $display("FAIL inst_overflow error=%b left=%0d want 1/3", bus.error, host_q.size());
    end
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) inst_q.push_back(mk(12'h0FD + i, DW'(32'h50 + i), '0));
    push(hdr(0, 0, 12'h0FD, 3)); push(32'h50); push(32'h51); push(32'h52);
    wait_drain(cyc);
    total++;
    if (inst_q.size() !== 0 || bus.error !== 1'b0) begin
      bad++; $display("FAIL inst_top_fit pending=%0d error=%b want 0/0", inst_q.size(), bus.error);
    end
    @(negedge clk);
    p0 = pops;
    push(hdr(2, 0, 12'h100, 0));
    @(negedge clk);
    total++;
    if (pops - p0 !== 1 || bus.busy !== 1'b0 || bus.error !== 1'b0) begin
      bad++; $display("FAIL len0 pops=%0d busy=%b err=%b want 1/0/0", pops - p0, bus.busy, bus.error);
    end
  endtask

  task automatic test_empty_stall();
    int cyc;
    @(negedge clk);
    xy_q.push_back(mk(12'h3FE, 32'hAB01, '0));
    xy_q.push_back(mk(12'h3FF, 32'hAB02, '0));
    push(hdr(2, 0, 12'h3FE, 2)); push(32'hAB01);
    repeat (4) @(negedge clk);
    #3;
    total++;
    if (bus.busy !== 1'b1 || bus.xy_write_enable !== 1'b0 || xy_q.size() !== 1) begin
      bad++; $display("FAIL empty_hold busy=%b xy_we=%b pending=%0d want 1/0/1", bus.busy, bus.xy_write_enable, xy_q.size());
    end
    @(negedge clk);
    push(32'hAB02);
    wait_drain(cyc);
    total++;
    if (xy_q.size() !== 0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL empty_resume pending=%0d busy=%b want 0/0", xy_q.size(), bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [DW-1:0] d[3];
    @(negedge clk);
    for (int i = 0; i < 3; i++) d[i] = $urandom();
    xy_q.push_back(mk(12'h000, d[0], '0));
    xy_q.push_back(mk(12'h001, d[1], '0));
    w_q.push_back(mk(12'h1FF, d[2], 8'b1000_0000));
    push(hdr(2, 0, 0, 2)); push(d[0]); push(d[1]);
    push(hdr(1, 7, 12'h1FF, 1)); push(d[2]);
    wait_drain(cyc);
    total++;
    if (xy_q.size() !== 0 || w_q.size() !== 0 || cyc !== 5) begin
      bad++; $display("FAIL b2b pending=%0d/%0d cycles=%0d want 0/0/5", xy_q.size(), w_q.size(), cyc);
    end
  endtask

  task automatic test_bcast();
    int cyc;
    @(negedge clk);
`ifdef HOST_LOAD_BCAST_EN
    w_q.push_back(mk(0, 32'hB0, 8'hFF));
    w_q.push_back(mk(1, 32'hB1, 8'hFF));
    push(hdr(1, 63, 0, 2)); push(32'hB0); push(32'hB1);
    wait_drain(cyc);
    total++;
    if (w_q.size() !== 0 || bus.error !== 1'b0) begin
      bad++; $display("FAIL bcast pending=%0d error=%b want 0/0", w_q.size(), bus.error);
    end
`else
    cyc = 0;
    push(hdr(1, 63, 0, 2)); push(32'hB0); push(32'hB1);
    repeat (3) @(negedge clk);
    total++;
    if (bus.error !== 1'b1 || host_q.size() !== 2 || cyc !== 0) begin
      bad++; $display("FAIL bank63_error error=%b left=%0d want 1/2", bus.error, host_q.size());
    end
`endif
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    bus.ctrl_xy_write_enable = 1'b0;
    bus.ctrl_xy_write_addr   = '0;
    bus.ctrl_xy_write_data   = '0;
    refresh();
    test_reset();
    test_inst_load();
    test_w_load();
    test_xy_conflict();
    test_run_gating();
    test_bad_bank();
    test_bounds();
    test_empty_stall();
    test_back_to_back();
    test_bcast();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
